// File: rtl/rx_fifo_arbiter_pkg.sv
// ============================================================================
// Module   : rx_arb_pkg
// Brief    : Shared types and constants for the receive FIFO arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_arb_pkg;

    localparam int c_DATA_W  = 32;
    localparam int c_IDX_W   = 4;
    localparam int c_TAG_LSB = 28;
    localparam int c_TAG_W   = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rx_fifo_arbiter_if.sv
// ============================================================================
// Module   : rx_fifo_arbiter_if
// Brief    : Channel-side and downstream-side signal bundle of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rx_fifo_arbiter_if #(
    parameter int NUM_CH = 4
);
    import rx_arb_pkg::*;

    logic [NUM_CH-1:0]          CH_EMPTY;
    logic [c_DATA_W*NUM_CH-1:0] CH_DATA;
    logic [NUM_CH-1:0]          CH_READ;
    logic [NUM_CH-1:0]          CH_ENABLE;
    logic                       FIFO_READ;
    logic                       FIFO_EMPTY;
    logic [c_DATA_W-1:0]        FIFO_DATA;
    logic [c_IDX_W-1:0]         GRANT;
    logic                       BUSY;

    modport master (
        input  CH_EMPTY, CH_DATA, CH_ENABLE, FIFO_READ,
        output CH_READ, FIFO_EMPTY, FIFO_DATA, GRANT, BUSY
    );

    modport slave (
        output CH_EMPTY, CH_DATA, CH_ENABLE, FIFO_READ,
        input  CH_READ, FIFO_EMPTY, FIFO_DATA, GRANT, BUSY
    );

endinterface

`default_nettype wire

// File: rtl/rx_fifo_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational circular priority search starting after i_last.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import rx_arb_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  wire logic [NUM_CH-1:0]  i_req,
    input  wire logic [c_IDX_W-1:0] i_last,
    output logic                    o_valid,
    output logic [c_IDX_W-1:0]      o_idx
);

    int w_dist;
    int w_best;

    // Distance of each channel from the slot just after i_last; smallest wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_dist  = 0;
        w_best  = NUM_CH;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_dist = (ch + NUM_CH - 1 - int'(i_last)) % NUM_CH;
            if (i_req[ch] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_idx   = c_IDX_W'(ch);
                o_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rx_fifo_arbiter.sv
// ============================================================================
// Module   : rx_fifo_arbiter
// Brief    : Round-robin burst arbiter merging NUM_CH FWFT FIFOs into one
//            single-word output register. RX_ARB_CHANNEL_TAG_EN puts the
//            channel index in FIFO_DATA[31:28].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_fifo_arbiter
    import rx_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int BURST_LEN = 16
) (
    input  wire logic          BUS_CLK,
    input  wire logic          BUS_RST_N,
    rx_fifo_arbiter_if.master  bus
);

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    arb_state_t          r_state, w_state_nxt;
    logic [c_IDX_W-1:0]  r_grant, w_grant_nxt;
    logic [c_IDX_W-1:0]  r_last, w_last_nxt;
    logic [7:0]          r_count, w_count_nxt;
    logic                r_full, w_full_nxt;
    logic [c_DATA_W-1:0] r_data, w_data_nxt;
    logic [NUM_CH-1:0]   w_req, w_sel, w_rd;
    logic                w_pick_valid;
    logic [c_IDX_W-1:0]  w_pick_idx;
    logic                w_ch_empty, w_ch_en, w_xfer;
    logic [c_DATA_W-1:0] w_ch_word, w_load_word;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) r_rst_sync <= 2'b00;
        else            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_req = bus.CH_ENABLE & ~bus.CH_EMPTY;

    rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_sel      = '0;
        w_ch_empty = 1'b1;
        w_ch_en    = 1'b0;
        w_ch_word  = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (r_grant == c_IDX_W'(n)) begin
                w_sel[n]   = 1'b1;
                w_ch_empty = bus.CH_EMPTY[n];
                w_ch_en    = bus.CH_ENABLE[n];
                w_ch_word  = bus.CH_DATA[c_DATA_W*n +: c_DATA_W];
            end
        end
    end

`ifdef RX_ARB_CHANNEL_TAG_EN
    assign w_load_word = {r_grant[c_TAG_W-1:0], w_ch_word[c_TAG_LSB-1:0]};
`else
    assign w_load_word = w_ch_word;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_count_nxt = r_count;
        w_full_nxt  = r_full;
        w_data_nxt  = r_data;
        w_rd        = '0;
        w_xfer      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt = w_pick_idx;
                    w_count_nxt = '0;
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (!w_ch_empty && w_ch_en) begin
                    if (!r_full || bus.FIFO_READ) begin
                        w_xfer      = 1'b1;
                        w_rd        = w_sel;
                        w_count_nxt = r_count + 8'd1;
                        if ((r_count + 8'd1) == 8'(BURST_LEN)) begin
                            w_state_nxt = IDLE;
                            w_last_nxt  = r_grant;
                        end
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_grant;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // A load and a downstream pop in the same cycle simply replace the word.
        if (w_xfer) begin
            w_full_nxt = 1'b1;
            w_data_nxt = w_load_word;
        end else if (bus.FIFO_READ) begin
            w_full_nxt = 1'b0;
        end
    end

    always_ff @(posedge BUS_CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= c_IDX_W'(NUM_CH - 1);
            r_count <= '0;
            r_full  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_count <= w_count_nxt;
            r_full  <= w_full_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign bus.CH_READ    = w_rd;
    assign bus.FIFO_EMPTY = ~r_full;
    assign bus.FIFO_DATA  = r_data;
    assign bus.GRANT      = r_grant;
    assign bus.BUSY       = (r_state == XFER);

endmodule

`default_nettype wire

// File: tb/tb_rx_fifo_arbiter.sv
// ============================================================================
// Module   : tb_rx_fifo_arbiter
// Brief    : Directed self-checking bench for rx_fifo_arbiter (4 ch, burst 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_fifo_arbiter;
    import rx_arb_pkg::*;

    localparam int c_NUM_CH = 4;
    localparam int c_BURST  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rx_fifo_arbiter_if #(.NUM_CH(c_NUM_CH)) bus ();

    rx_fifo_arbiter #(.NUM_CH(c_NUM_CH), .BURST_LEN(c_BURST)) dut (
        .BUS_CLK   (clk),
        .BUS_RST_N (rst_n),
        .bus       (bus)
    );

    logic [31:0] chq [c_NUM_CH][$];
    int          pop_log [$];
    logic [31:0] out_log [$];
    int          ch_pops [c_NUM_CH];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        for (int n = 0; n < c_NUM_CH; n++) begin
            bus.CH_EMPTY[n]          = (chq[n].size() == 0);
            bus.CH_DATA[32*n +: 32]  = (chq[n].size() == 0) ? 32'h0 : chq[n][0];
        end
    endtask

    // One clock: sample at negedge, apply channel pops just after posedge.
    task automatic step();
        logic [c_NUM_CH-1:0] rd;
        logic                opop;
        logic [31:0]         oword;
        int                  who;
        @(negedge clk);
        rd    = bus.CH_READ;
        opop  = bus.FIFO_READ && !bus.FIFO_EMPTY;
        oword = bus.FIFO_DATA;
        who   = -1;
        check("ch_read_onehot", 64'($countones(rd) <= 1), 64'd1);
        for (int n = 0; n < c_NUM_CH; n++) if (rd[n]) who = n;
        @(posedge clk);
        #1;
        for (int n = 0; n < c_NUM_CH; n++) begin
            if (rd[n]) begin
                check($sformatf("pop_nonempty_ch%0d", n), 64'(chq[n].size() != 0), 64'd1);
                if (chq[n].size() != 0) void'(chq[n].pop_front());
                ch_pops[n]++;
            end
        end
        pop_log.push_back(who);
        if (opop) out_log.push_back(oword);
        refresh();
    endtask

    task automatic drain(input int max);
        bit done;
        bit qe;
        done = 1'b0;
        bus.FIFO_READ = 1'b1;
        bus.CH_ENABLE = '1;
        for (int k = 0; k < max && !done; k++) begin
            step();
            qe = 1'b1;
            for (int n = 0; n < c_NUM_CH; n++) if (chq[n].size() != 0) qe = 1'b0;
            done = qe && bus.FIFO_EMPTY && !bus.BUSY;
        end
        check("drain_done", 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp_log [$];
        int          bursts [5];
        int          first;
        logic [31:0] exp_word;

        bursts = '{0, 1, 2, 3, 0};
        for (int n = 0; n < c_NUM_CH; n++) ch_pops[n] = 0;
        rst_n         = 1'b0;
        bus.CH_ENABLE = '1;
        bus.FIFO_READ = 1'b0;
        bus.CH_EMPTY  = '1;
        bus.CH_DATA   = '0;
        refresh();
        repeat (3) @(posedge clk);
        #1;
        check("rst_fifo_empty", bus.FIFO_EMPTY, 1);
        check("rst_fifo_data",  bus.FIFO_DATA,  0);
        check("rst_grant",      bus.GRANT,      0);
        check("rst_busy",       bus.BUSY,       0);
        check("rst_ch_read",    bus.CH_READ,    0);
        rst_n = 1'b1;
        repeat (3) step();

        // All four channels loaded: round-robin 0,1,2,3,0 with an idle gap.
        for (int ch = 0; ch < c_NUM_CH; ch++)
            for (int k = 0; k < ((ch == 0) ? 8 : 4); k++)
                chq[ch].push_back({4'(ch), 20'h0, 8'(k)});
        bus.FIFO_READ = 1'b1;
        pop_log.delete();
        out_log.delete();
        refresh();
        repeat (30) step();
        for (int b = 0; b < 5; b++) begin
            exp_log.push_back(-1);
            for (int k = 0; k < 4; k++) exp_log.push_back(bursts[b]);
        end
        for (int i = 0; i < 25; i++)
            check($sformatf("rr_cycle%0d", i), pop_log[i], exp_log[i]);
        check("rr_out_count", out_log.size(), 20);
        for (int i = 0; i < 20; i++) begin
            exp_word = {4'(bursts[i/4]), 20'h0, 8'((i >= 16) ? (i - 12) : (i % 4))};
            if (i < out_log.size()) check($sformatf("rr_word%0d", i), out_log[i], exp_word);
        end
        drain(10);

        // Channel 2 alone: latency and in-order delivery.
        out_log.delete();
        bus.FIFO_READ = 1'b1;
        for (int k = 1; k <= 5; k++) chq[2].push_back({4'd2, 20'hABCDE, 8'(k)});
        refresh();
        step();
        check("lat_edge1_empty", bus.FIFO_EMPTY, 1);
        check("lat_grant",       bus.GRANT,      2);
        check("lat_busy",        bus.BUSY,       1);
        step();
        check("lat_edge2_empty", bus.FIFO_EMPTY, 0);
        check("lat_edge2_data",  bus.FIFO_DATA,  {4'd2, 20'hABCDE, 8'd1});
        repeat (12) step();
        check("ch2_out_count", out_log.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < out_log.size()) check($sformatf("ch2_word%0d", k), out_log[k], {4'd2, 20'hABCDE, 8'(k + 1)});
        drain(10);

        // Downstream stall: one pop only, output word held.
        bus.FIFO_READ = 1'b0;
        for (int n = 0; n < c_NUM_CH; n++) ch_pops[n] = 0;
        for (int k = 0; k < 3; k++) chq[1].push_back({4'd1, 20'h0C0C0, 8'(k)});
        refresh();
        repeat (12) step();
        check("stall_pops",  ch_pops[1],     1);
        check("stall_data",  bus.FIFO_DATA,  {4'd1, 20'h0C0C0, 8'd0});
        check("stall_empty", bus.FIFO_EMPTY, 0);
        check("stall_busy",  bus.BUSY,       1);
        bus.FIFO_READ = 1'b1;
        step();
        check("stall_resume_pops", ch_pops[1],    2);
        check("stall_resume_data", bus.FIFO_DATA, {4'd1, 20'h0C0C0, 8'd1});
        drain(10);

        // Channel 1 disabled mid-burst: grant moves to channel 2.
        for (int n = 0; n < c_NUM_CH; n++) ch_pops[n] = 0;
        bus.FIFO_READ = 1'b1;
        for (int k = 0; k < 6; k++) chq[1].push_back({4'd1, 20'h0D0D0, 8'(k)});
        refresh();
        step();
        check("dis_grant1", bus.GRANT, 1);
        step();
        check("dis_pre_pops", ch_pops[1], 1);
        for (int k = 0; k < 2; k++) chq[2].push_back({4'd2, 20'h0D0D0, 8'(k)});
        bus.CH_ENABLE = 4'b1101;
        refresh();
        #1;
        check("dis_rd1_now", bus.CH_READ[1], 0);
        step();
        step();
        check("dis_grant2", bus.GRANT, 2);
        check("dis_busy",   bus.BUSY,  1);
        repeat (8) step();
        check("dis_ch1_pops", ch_pops[1], 1);
        check("dis_ch2_pops", ch_pops[2], 2);
        drain(30);

        // Reset pulse mid-burst, then the next grant is channel 0.
        bus.FIFO_READ = 1'b1;
        for (int k = 0; k < 6; k++) chq[3].push_back({4'd3, 20'h0E0E0, 8'(k)});
        refresh();
        repeat (3) step();
        check("mid_busy", bus.BUSY, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_empty",   bus.FIFO_EMPTY, 1);
        check("mid_rst_ch_read", bus.CH_READ,    0);
        check("mid_rst_data",    bus.FIFO_DATA,  0);
        check("mid_rst_busy",    bus.BUSY,       0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chq[0].push_back({4'd0, 20'h0F0F0, 8'(k)});
            chq[2].push_back({4'd2, 20'h0F0F0, 8'(k)});
        end
        refresh();
        pop_log.delete();
        first = -1;
        for (int k = 0; k < 10 && first < 0; k++) begin
            step();
            first = pop_log[pop_log.size() - 1];
        end
        check("rst_regrant_ch0", first, 0);
        drain(40);

        // Channel tag field on an all-ones word from channel 3.
        bus.FIFO_READ = 1'b0;
        chq[3].push_back(32'hFFFF_FFFF);
        refresh();
        step();
        step();
        check("tag_empty", bus.FIFO_EMPTY, 0);
`ifdef RX_ARB_CHANNEL_TAG_EN
        check("tag_data", bus.FIFO_DATA, 32'h3FFF_FFFF);
`else
        check("tag_data", bus.FIFO_DATA, 32'hFFFF_FFFF);
`endif
        drain(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rx_fifo_arbiter.md
RX_FIFO_ARBITER -- requirements
Module: rx_fifo_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of receiver FIFOs shared (2..16).
REQ-002 SHALL have parameter BURST_LEN, default 16, maximum words taken from one channel per grant (1..255).
REQ-003 SHALL have port BUS_CLK  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port BUS_RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port CH_EMPTY  input  NUM_CH  per-channel FIFO empty; CH_DATA slice valid when low (first-word-fall-through).
REQ-006 SHALL have port CH_DATA  input  32*NUM_CH  channel n word at bits [32n+31:32n].
REQ-007 SHALL have port CH_READ  output  NUM_CH  one-cycle pop strobe per channel.
REQ-008 SHALL have port CH_ENABLE  input  NUM_CH  channel mask; a disabled channel is never granted.
REQ-009 SHALL have port FIFO_READ  input  1  downstream pop of the output word.
REQ-010 SHALL have port FIFO_EMPTY  output  1  high when the output register holds no word.
REQ-011 SHALL have port FIFO_DATA  output  32  output word, valid while FIFO_EMPTY low.
REQ-012 SHALL have port GRANT  output  4  index of the currently granted channel.
REQ-013 SHALL have port BUSY  output  1  high in state XFER.

Function
REQ-014 SHALL implement states IDLE and XFER.
REQ-015 IDLE: if any channel has CH_ENABLE=1 and CH_EMPTY=0, SHALL latch GRANT as the first such index searching circularly from last_grant+1 and enter XFER next cycle with burst count 0; otherwise stay in IDLE.
REQ-016 XFER: a transfer SHALL occur in a cycle where CH_EMPTY[GRANT]=0, CH_ENABLE[GRANT]=1 and (FIFO_EMPTY=1 or FIFO_READ=1).
REQ-017 On a transfer, CH_READ[GRANT] SHALL be high for that cycle only, the output register SHALL load CH_DATA[GRANT] at the next edge, and the burst count SHALL increment.
REQ-018 At most one CH_READ bit SHALL be high in any cycle; CH_READ SHALL be zero in IDLE.
REQ-019 XFER SHALL return to IDLE after the transfer that makes the count equal BURST_LEN, or in any cycle where CH_EMPTY[GRANT]=1 or CH_ENABLE[GRANT]=0 (no transfer that cycle); last_grant SHALL then equal GRANT.
REQ-020 Latency: from CH_EMPTY falling with the arbiter in IDLE and output empty, FIFO_EMPTY SHALL fall on the 2nd rising edge.
REQ-021 Throughput in XFER SHALL be one word per cycle when FIFO_READ is held high.
REQ-022 FIFO_READ with FIFO_EMPTY=1 SHALL be ignored; FIFO_READ and a load in the same cycle SHALL replace the word with no bubble.
REQ-023 Round-robin search SHALL wrap from NUM_CH-1 to 0; with a single requester it SHALL re-grant the same channel after one IDLE cycle.
REQ-024 Words SHALL never be dropped or duplicated; per-channel order SHALL be preserved.

Reset
REQ-025 BUS_RST_N low SHALL immediately force state IDLE, CH_READ=0, FIFO_EMPTY=1, FIFO_DATA=0, GRANT=0, BUS_Y=0, burst count 0, last_grant=NUM_CH-1.
REQ-026 Reset asserted mid-burst SHALL discard the output register word; release SHALL be synchronised so the first active edge starts in IDLE.

Configuration
REQ-027 Macro RX_ARB_CHANNEL_TAG_EN defined: FIFO_DATA[31:28] SHALL equal the granting channel index and [27:0] the channel word bits [27:0].
REQ-028 Macro undefined: FIFO_DATA SHALL be the channel word unmodified, all 32 bits.

Structure
REQ-029 Package rx_arb_pkg SHALL hold the state enum (IDLE, XFER), the data width constant 32, and the tag field position/width.
REQ-030 Circular priority search SHALL be a sub-module rr_pick (inputs request mask, last index; outputs valid, index), purely combinational.

Verification
REQ-031 Channel 2 only, 5 words, FIFO_READ held high -> 5 words in order, GRANT=2, FIFO_EMPTY falls 2 cycles after CH_EMPTY[2] falls.
REQ-032 All 4 channels full, BURST_LEN=4 -> grant order 0,1,2,3,0; exactly 4 words per grant; one IDLE cycle between bursts.
REQ-033 FIFO_READ low for 10 cycles during XFER -> exactly one CH_READ pulse, FIFO_DATA stable, no further pops until FIFO_READ.
REQ-034 CH_ENABLE[1] cleared mid-burst -> no further CH_READ[1] in that cycle or after; grant moves to channel 2.
REQ-035 BUS_RST_N low for one cycle mid-burst -> FIFO_EMPTY=1, CH_READ=0 immediately; next grant channel 0.
REQ-036 With RX_ARB_CHANNEL_TAG_EN, channel 3 word 32'hFFFF_FFFF -> FIFO_DATA=32'h3FFF_FFFF; without -> 32'hFFFF_FFFF.
